// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and its memory.
// One outstanding request; rvalid returns rdata for the most recently granted request.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one imem request at a time and fills the
// IF/ID register, with downstream stall and redirect/flush from a resolved jump.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 i_id_stall,
  input  logic                 i_redirect,
  input  logic [31:0]          i_redirect_pc,
  output logic                 o_if_valid,
  output logic [31:0]          o_if_inst,
  output logic [31:0]          o_if_pc,
  output logic [31:0]          o_if_pc_next
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_hold_inst;
  logic        r_kill;
  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_next;
  logic        w_out_free;

  assign w_out_free   = !r_if_valid || !i_id_stall;
  assign imem.req     = (r_state == S_ISSUE) && !rst;
  assign imem.addr    = r_pc;
  assign o_if_valid   = r_if_valid;
  assign o_if_inst    = r_if_inst;
  assign o_if_pc      = r_if_pc;
  assign o_if_pc_next = r_if_pc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_ISSUE;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_hold_inst  <= NOP_INST;
      r_kill       <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_inst    <= NOP_INST;
      r_if_pc      <= 32'h0;
      r_if_pc_next <= 32'h0;
    end else if (i_redirect) begin
      r_pc       <= i_redirect_pc;
      r_if_valid <= 1'b0;
      r_if_inst  <= NOP_INST;
      // A request already granted for the old path must still be drained, so mark it killed.
      case (r_state)
        S_ISSUE: begin
          if (imem.gnt) begin
            r_kill  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            r_kill  <= 1'b0;
            r_state <= S_ISSUE;
          end else begin
            r_kill <= 1'b1;
          end
        end
        default: r_state <= S_ISSUE;
      endcase
    end else begin
      if (w_out_free) begin
        r_if_valid <= 1'b0;
        r_if_inst  <= NOP_INST;
      end
      case (r_state)
        S_ISSUE: begin
          if (imem.gnt) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_STEP;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.rvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= S_ISSUE;
            end else if (w_out_free) begin
              r_if_valid   <= 1'b1;
              r_if_inst    <= imem.rdata;
              r_if_pc      <= r_req_pc;
              r_if_pc_next <= r_req_pc + PC_STEP;
              r_state      <= S_ISSUE;
            end else begin
              r_hold_inst <= imem.rdata;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // r_req_pc is still the parked word's address: no new request issues from HOLD.
          if (w_out_free) begin
            r_if_valid   <= 1'b1;
            r_if_inst    <= r_hold_inst;
            r_if_pc      <= r_req_pc;
            r_if_pc_next <= r_req_pc + PC_STEP;
            r_state      <= S_ISSUE;
          end
        end
        default: r_state <= S_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory model plus an in-order program-stream
// reference (sequential PCs, restarted at each redirect target).
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_next;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(32'd4), .NOP_INST(NOP_INST)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_bus),
    .i_id_stall    (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_if_valid    (if_valid),
    .o_if_inst     (if_inst),
    .o_if_pc       (if_pc),
    .o_if_pc_next  (if_pc_next)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int consumed = 0;

  logic [31:0] fetch_pc;
  logic [31:0] exp_pc;
  logic        pending;
  logic        delivering;
  logic [31:0] paddr;
  int          lat;
  logic        flush_chk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    fetch_pc  = RESET_PC;
    exp_pc    = RESET_PC;
    pending   = 1'b0;
    flush_chk = 1'b0;
    lat       = 0;
  endtask

  // mode 0: random; 1: ideal memory, gap checked; 2: ideal memory, stalled;
  // 3: ideal memory; 4: like 3 with a redirect to wrap_pc on the first cycle
  task automatic run(input int n, input int mode, input logic [31:0] wrap_pc);
    int last_cons;
    last_cons = -1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (flush_chk) begin
        chk("flush_valid", {31'b0, if_valid}, 32'h0);
        flush_chk = 1'b0;
      end
      delivering      = 1'b0;
      imem_bus.rvalid = 1'b0;
      imem_bus.rdata  = $urandom;
      if (pending) begin
        if (lat == 0) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata  = mem_word(paddr);
          pending         = 1'b0;
          delivering      = 1'b1;
        end else begin
          lat--;
        end
      end else if (mode == 0 && imem_bus.req && $urandom_range(3) == 0) begin
        imem_bus.rvalid = 1'b1;
      end
      imem_bus.gnt = (mode != 0) ? 1'b1 : ($urandom_range(9) < 7);
      stall        = (mode == 2) ? 1'b1 : (mode == 0) ? ($urandom_range(3) == 0) : 1'b0;
      redirect     = (mode == 0) ? ($urandom_range(19) == 0) : (mode == 4 && c == 0);
      redirect_pc  = (mode == 4) ? wrap_pc : ($urandom & 32'hFFFF_FFFC);

      @(negedge clk);
      if (imem_bus.req) chk("imem_addr", imem_bus.addr, fetch_pc);
      chk("one_outstanding", {31'b0, imem_bus.req & (pending | delivering)}, 32'h0);
      if (!if_valid) chk("nop_inst", if_inst, NOP_INST);
      if (if_valid && !stall && !redirect) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_inst", if_inst, mem_word(exp_pc));
        chk("if_pc_next", if_pc_next, exp_pc + 32'd4);
        if (mode == 1 && last_cons >= 0) chk("gap", c - last_cons, 32'd2);
        last_cons = c;
        exp_pc    = exp_pc + 32'd4;
        consumed++;
      end
      if (mode == 2 && c == n - 1) begin
        chk("hold_req", {31'b0, imem_bus.req}, 32'h0);
        chk("hold_valid", {31'b0, if_valid}, 32'h1);
      end
      if (imem_bus.req && imem_bus.gnt) begin
        pending = 1'b1;
        paddr   = imem_bus.addr;
        lat     = (mode == 0) ? $urandom_range(2) : 0;
      end
      if (redirect) begin
        fetch_pc  = redirect_pc;
        exp_pc    = redirect_pc;
        flush_chk = 1'b1;
      end else if (imem_bus.req && imem_bus.gnt) begin
        fetch_pc = fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_bus.req}, 32'h0);
    chk("rst_inst", if_inst, NOP_INST);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc_next", if_pc_next, 32'h0);
  endtask

  task automatic async_reset_pulse();
    @(posedge clk); #3;
    rst = 1'b1;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0;
    stall = 1'b0; redirect = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    imem_bus.rvalid = 1'b1;
    imem_bus.rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("first_req", {31'b0, imem_bus.req}, 32'h1);
    chk("first_addr", imem_bus.addr, RESET_PC);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_bus.gnt = 1'b0; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    run(12, 1, 32'h0);
    run(6, 2, 32'h0);
    run(10, 3, 32'h0);
    run(3000, 0, 32'h0);
    async_reset_pulse();
    run(10, 1, 32'h0);
    run(12, 4, 32'hFFFF_FFF8);
    run(2000, 0, 32'h0);
    chk("progress", {31'b0, consumed >= 300}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
